// File: rtl/sprite_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sprite_fetch                                                 |
// | Description : Sprite RAM address generator with 2-stage opaque-pixel        |
// |               pipeline and frame-counted animation stepping.               |
// |               Optional horizontal mirroring via `define SPRITE_MIRROR_EN.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sprite_fetch #(
    parameter int         SPR_W       = 20,
    parameter int         SPR_H       = 20,
    parameter int         N_FRAMES    = 4,
    parameter int         FRAME_TICKS = 8,
    parameter logic [5:0] TRANSP      = 6'h00,
    localparam int        FW          = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [9:0]    DrawX,
    input  logic [9:0]    DrawY,
    input  logic          pix_valid,
    input  logic [9:0]    SprX,
    input  logic [9:0]    SprY,
    input  logic          anim_en,
    input  logic          frame_vs,
`ifdef SPRITE_MIRROR_EN
    input  logic          mirror_x,
`endif
    output logic [18:0]   read_address,
    input  logic [5:0]    rom_data,
    output logic [5:0]    pix_out,
    output logic          pix_hit,
    output logic [FW-1:0] frame_idx
);

    localparam int        TW          = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam [TW-1:0]   c_tick_last = TW'(FRAME_TICKS - 1);
    localparam [FW-1:0]   c_frame_last = FW'(N_FRAMES - 1);
    localparam [18:0]     c_frame_size = 19'(SPR_W * SPR_H);

    logic          r_s1_in;
    logic [TW-1:0] r_tick;

    logic [10:0]   w_x, w_y, w_sx, w_sy;
    logic          w_inside;
    logic [9:0]    w_col_raw, w_col, w_row;
    logic [18:0]   w_addr;
    logic          w_opaque;
    logic          w_step;

    // Comparisons carried at 11 bits so a sprite near the right edge cannot wrap.
    assign w_x      = {1'b0, DrawX};
    assign w_y      = {1'b0, DrawY};
    assign w_sx     = {1'b0, SprX};
    assign w_sy     = {1'b0, SprY};
    assign w_inside = pix_valid
                    & (w_x >= w_sx) & (w_x < (w_sx + 11'(SPR_W)))
                    & (w_y >= w_sy) & (w_y < (w_sy + 11'(SPR_H)));

    assign w_col_raw = DrawX - SprX;
    assign w_row     = DrawY - SprY;
`ifdef SPRITE_MIRROR_EN
    assign w_col = mirror_x ? (10'(SPR_W - 1) - w_col_raw) : w_col_raw;
`else
    assign w_col = w_col_raw;
`endif

    assign w_addr = 19'(frame_idx) * c_frame_size
                  + 19'(w_row) * 19'(SPR_W)
                  + 19'(w_col);

    assign w_opaque = r_s1_in & (rom_data != TRANSP);
    assign w_step   = frame_vs & anim_en;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address <= '0;
            r_s1_in      <= 1'b0;
            pix_hit      <= 1'b0;
            pix_out      <= TRANSP;
        end else begin
            if (w_inside)
                read_address <= w_addr;
            r_s1_in <= w_inside;
            pix_hit <= w_opaque;
            pix_out <= w_opaque ? rom_data : TRANSP;
        end
    end

    // The address above samples frame_idx before this update, so a pixel
    // coinciding with frame_vs still uses the old frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_tick    <= '0;
            frame_idx <= '0;
        end else if (w_step) begin
            if (r_tick == c_tick_last) begin
                r_tick    <= '0;
                frame_idx <= (frame_idx == c_frame_last) ? '0 : frame_idx + 1'b1;
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sprite_fetch                                              |
// | Description : Directed self-checking bench for sprite_fetch                |
// |               (N_FRAMES=3, FRAME_TICKS=2, 20x20 sprite).                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, SprX = '0, SprY = '0;
    logic        pix_valid = 1'b0, anim_en = 1'b0, frame_vs = 1'b0;
`ifdef SPRITE_MIRROR_EN
    logic        mirror_x = 1'b0;
`endif
    logic [18:0] read_address;
    logic [5:0]  rom_data;
    logic [5:0]  pix_out;
    logic        pix_hit;
    logic [1:0]  frame_idx;

    logic        use_rom = 1'b0;
    logic [5:0]  rom_drv = 6'h00;

    int n_checks = 0;
    int n_fail   = 0;

    // Sprite RAM model: either a driven constant or a never-transparent
    // function of the address presented on the previous edge.
    assign rom_data = use_rom ? (read_address[5:0] | 6'h20) : rom_drv;

    always #5 Clk = ~Clk;

    sprite_fetch #(
        .SPR_W       (20),
        .SPR_H       (20),
        .N_FRAMES    (3),
        .FRAME_TICKS (2),
        .TRANSP      (6'h00)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .pix_valid    (pix_valid),
        .SprX         (SprX),
        .SprY         (SprY),
        .anim_en      (anim_en),
        .frame_vs     (frame_vs),
`ifdef SPRITE_MIRROR_EN
        .mirror_x     (mirror_x),
`endif
        .read_address (read_address),
        .rom_data     (rom_data),
        .pix_out      (pix_out),
        .pix_hit      (pix_hit),
        .frame_idx    (frame_idx)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int x, input int y);
        DrawX     = 10'(x);
        DrawY     = 10'(y);
        pix_valid = 1'b1;
    endtask

    task automatic pulse();
        frame_vs = 1'b1;
        step();
        frame_vs = 1'b0;
    endtask

    initial begin
        int exp_seq[6];
        exp_seq = '{0, 1, 1, 2, 2, 0};

        // Reset state
        #12;
        chk("rst_addr",  32'(read_address), 32'd0);
        chk("rst_pix",   32'(pix_out),      32'h00);
        chk("rst_hit",   32'(pix_hit),      32'd0);
        chk("rst_frame", 32'(frame_idx),    32'd0);
        #10 Reset_n = 1'b1;

        // Basic hit in frame 0
        SprX = 10'd100; SprY = 10'd50;
        req(105, 52);
        step();
        chk("hit_addr", 32'(read_address), 32'd45);
        pix_valid = 1'b0; rom_drv = 6'h0A;
        step();
        chk("hit_flag", 32'(pix_hit), 32'd1);
        chk("hit_pix",  32'(pix_out), 32'h0A);
        chk("hit_hold", 32'(read_address), 32'd45);

        // Left and right boundary misses
        req(99, 52);
        step();
        chk("left_addr", 32'(read_address), 32'd45);
        pix_valid = 1'b0;
        step();
        chk("left_hit", 32'(pix_hit), 32'd0);
        chk("left_pix", 32'(pix_out), 32'h00);
        req(120, 52);
        step();
        chk("right_addr", 32'(read_address), 32'd45);
        pix_valid = 1'b0;
        step();
        chk("right_hit", 32'(pix_hit), 32'd0);
        req(100, 70);
        step();
        chk("bottom_addr", 32'(read_address), 32'd45);
        pix_valid = 1'b0;
        step();
        chk("bottom_hit", 32'(pix_hit), 32'd0);

        // Sprite near right screen edge must not wrap
        SprX = 10'd1015;
        req(1020, 53);
        step();
        chk("edge_addr", 32'(read_address), 32'd65);
        pix_valid = 1'b0;
        step();
        chk("edge_hit", 32'(pix_hit), 32'd1);
        SprX = 10'd100;

        // Transparent pixel inside the sprite
        rom_drv = 6'h00;
        req(110, 55);
        step();
        chk("transp_addr", 32'(read_address), 32'd110);
        pix_valid = 1'b0;
        step();
        chk("transp_hit", 32'(pix_hit), 32'd0);
        chk("transp_pix", 32'(pix_out), 32'h00);

        // 20 back-to-back requests along row 2
        use_rom = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            if (n < 20) req(100 + n, 52);
            else        pix_valid = 1'b0;
            step();
            chk("stream_addr", 32'(read_address), 32'(40 + ((n < 20) ? n : 19)));
            if (n >= 1) begin
                chk("stream_hit", 32'(pix_hit), 32'd1);
                chk("stream_pix", 32'(pix_out), 32'((40 + n - 1) | 32'h20));
            end
        end
        use_rom = 1'b0;
        step();
        chk("stream_drain", 32'(pix_hit), 32'd0);

        // Animation: FRAME_TICKS=2, N_FRAMES=3
        anim_en = 1'b1;
        for (int p = 0; p < 6; p++) begin
            pulse();
            chk("anim_seq", 32'(frame_idx), 32'(exp_seq[p]));
        end
        anim_en = 1'b0;
        pulse();
        pulse();
        chk("anim_hold", 32'(frame_idx), 32'd0);
        anim_en = 1'b1;
        pulse();
        chk("anim_tick_hold", 32'(frame_idx), 32'd0);
        pulse();
        chk("anim_to1", 32'(frame_idx), 32'd1);

        // Frame 1 addressing, and frame_vs coincident with a request
        req(100, 50);
        step();
        chk("f1_addr", 32'(read_address), 32'd400);
        pix_valid = 1'b0;
        pulse();
        req(101, 50);
        pulse();
        pix_valid = 1'b0;
        chk("f1_vs_addr", 32'(read_address), 32'd401);
        chk("f1_vs_frame", 32'(frame_idx), 32'd2);

        // Asynchronous reset mid-stream
        rom_drv = 6'h0A;
        req(105, 52);
        step();
        chk("f2_addr", 32'(read_address), 32'd845);
        req(106, 52);
        step();
        chk("f2_hit", 32'(pix_hit), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_addr",  32'(read_address), 32'd0);
        chk("arst_hit",   32'(pix_hit),      32'd0);
        chk("arst_pix",   32'(pix_out),      32'h00);
        chk("arst_frame", 32'(frame_idx),    32'd0);
        pix_valid = 1'b0;
        #2 Reset_n = 1'b1;
        step();
        step();
        chk("post_rst_hit", 32'(pix_hit), 32'd0);

`ifdef SPRITE_MIRROR_EN
        mirror_x = 1'b1;
        req(100, 50);
        step();
        chk("mirror_addr", 32'(read_address), 32'd19);
        mirror_x = 1'b0;
`else
        req(119, 50);
        step();
        chk("col_last_addr", 32'(read_address), 32'd19);
`endif
        pix_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_fetch.md
SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 SHALL have parameter SPR_W, default 20, sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 20, sprite height in pixels.
REQ-003 SHALL have parameter N_FRAMES, default 4, number of animation frames stored back-to-back in the sprite RAM.
REQ-004 SHALL have parameter FRAME_TICKS, default 8, frame_vs pulses per animation step; legal range is 1 or greater.
REQ-005 SHALL have parameter TRANSP, default 6'h00, transparent palette index.
REQ-006 SHALL have port Clk, input, 1, the single clock, rising-edge active.
REQ-007 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports DrawX and DrawY, input, 10 each, the pixel coordinate being requested.
REQ-009 SHALL have port pix_valid, input, 1, which qualifies DrawX/DrawY in the current cycle.
REQ-010 SHALL have ports SprX and SprY, input, 10 each, the sprite top-left corner.
REQ-011 SHALL have port anim_en, input, 1, which enables animation stepping.
REQ-012 SHALL have port frame_vs, input, 1, a one-cycle pulse per video frame.
REQ-013 SHALL have port read_address, output, 19, registered, which drives the sprite RAM read port.
REQ-014 SHALL have port rom_data, input, 6, the sprite RAM data; it is valid one clock after read_address.
REQ-015 SHALL have port pix_out, output, 6, registered palette index.
REQ-016 SHALL have port pix_hit, output, 1, registered, meaning an opaque sprite pixel is present.
REQ-017 SHALL have port frame_idx, output, ceil(log2(N_FRAMES)) bits (minimum 1), the current animation frame.

Function
REQ-018 SHALL compute inside = pix_valid & (SprX <= DrawX < SprX+SPR_W) & (SprY <= DrawY < SprY+SPR_H), with all comparisons 11-bit unsigned so SprX+SPR_W never wraps.
REQ-019 SHALL, when inside, register read_address = frame_idx*SPR_W*SPR_H + (DrawY-SprY)*SPR_W + (DrawX-SprX), truncated to 19 bits.
REQ-020 SHALL hold read_address unchanged when inside is 0.
REQ-021 Pipeline stage 1 SHALL register a flag s1_in (= inside) at the same edge as read_address.
REQ-022 Stage 2 SHALL register, one edge later, pix_hit = s1_in & (rom_data != TRANSP) and pix_out = pix_hit ? rom_data : TRANSP.
REQ-023 Latency: a request sampled at edge k SHALL appear on pix_out/pix_hit after edge k+2; the block SHALL accept one request every cycle with no stalls.
REQ-024 The tick counter SHALL increment on frame_vs & anim_en; on reaching FRAME_TICKS-1 followed by another such pulse, it SHALL clear to 0 and frame_idx SHALL advance.
REQ-025 frame_idx SHALL wrap from N_FRAMES-1 to 0.
REQ-026 When anim_en is 0, the tick counter and frame_idx SHALL hold.
REQ-027 When frame_vs and pix_valid occur in the same cycle, that pixel SHALL use the pre-update frame_idx.

Reset
REQ-028 Reset_n low SHALL asynchronously clear read_address, pix_out (to TRANSP), pix_hit, s1_in, the tick counter and frame_idx to 0.
REQ-029 Requests in flight at reset SHALL be discarded; the first pix_hit after release SHALL reflect only requests sampled after release.

Configuration
REQ-030 With SPRITE_MIRROR_EN defined, the block SHALL add input mirror_x (1 bit); when mirror_x is 1, the column term SHALL be SPR_W-1-(DrawX-SprX).
REQ-031 Without SPRITE_MIRROR_EN, the mirror_x port SHALL be absent and the column term SHALL be DrawX-SprX.

Verification
REQ-032 Test: SprX=100, SprY=50, frame 0, request (105,52) -> read_address=45 after 1 edge; with rom_data=6'h0A, pix_hit=1 and pix_out=0A after 2 edges.
REQ-033 Test: request (99,52) or (120,52) -> pix_hit=0, pix_out=TRANSP, read_address unchanged; SprX=1015 with DrawX=1020 -> hit, no wrap.
REQ-034 Test: inside pixel with rom_data=TRANSP -> pix_hit=0; back-to-back inside requests over 20 consecutive cycles -> 20 consecutive results, none dropped.
REQ-035 Test: FRAME_TICKS=2, N_FRAMES=3, anim_en=1, 6 frame_vs pulses -> frame_idx sequence 0,0,1,1,2,2,0; anim_en=0 -> frame_idx holds.
REQ-036 Test: frame 1, request (100,50) -> read_address=400; frame_vs in the same cycle -> still 400.
REQ-037 Test: assert Reset_n low mid-stream between edges -> outputs clear immediately; with SPRITE_MIRROR_EN defined, mirror_x=1 and request (100,50) -> read_address=19.
